// File: rtl/pcs_pkg.sv
// Shared 100GbE PCS constants used by the TX block distribution and RX block collection sides.
package pcs_pkg;

    localparam int PCS_LEN_CODED_BLOCK = 66;
    localparam int PCS_N_LANES         = 20;
    localparam int PCS_LANE_ID_W       = $clog2(PCS_N_LANES);

endpackage : pcs_pkg

// File: rtl/block_collection_mux.sv
// RX block collection: captures one coded block per PCS lane in a single load and
// replays them as one block stream in ascending lane order, gap-free across back-to-back loads.
module block_collection_mux
    import pcs_pkg::*;
#(
    parameter int LEN_CODED_BLOCK = PCS_LEN_CODED_BLOCK,
    parameter int N_LANES         = PCS_N_LANES
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic [N_LANES*LEN_CODED_BLOCK-1:0] i_lanes_data,
    input  logic                               i_load,
    input  logic                               i_enable,
    output logic                               o_ready,
    output logic [LEN_CODED_BLOCK-1:0]         o_data,
    output logic                               o_valid,
    output logic [$clog2(N_LANES)-1:0]         o_lane_id,
    output logic                               o_overflow
);

    localparam int LANE_W = $clog2(N_LANES);
    localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(N_LANES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [LANE_W-1:0]          cnt_q, cnt_d;
    logic [LANE_W-1:0]          lane_id_q, lane_id_d;
    logic [LEN_CODED_BLOCK-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       overflow_q, overflow_d;
    logic [LEN_CODED_BLOCK-1:0] bank_q [N_LANES];

    logic at_last;
    logic emit;
    logic load_accept;

    assign at_last     = (cnt_q == LAST_IDX);
    assign emit        = (state_q == ST_DRAIN) && i_enable;
    assign o_ready     = !i_reset && ((state_q == ST_IDLE) || (emit && at_last));
    assign load_accept = i_load && o_ready;

    // NOTE: every variable gets a default before the conditionals, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        lane_id_d  = lane_id_q;
        valid_d    = 1'b0;
        overflow_d = i_load && !o_ready;

        if (emit) begin
            data_d    = bank_q[cnt_q];
            lane_id_d = cnt_q;
            valid_d   = 1'b1;
            if (at_last) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A load on the last drain cycle restarts the drain; the read above already used the old bank.
        if (load_accept) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            lane_id_q  <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            lane_id_q  <= lane_id_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the lane bank is not reset; it is only read after a load has filled it.
    always_ff @(posedge i_clock) begin
        if (load_accept) begin
            for (int k = 0; k < N_LANES; k++) begin
                bank_q[k] <= i_lanes_data[k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK];
            end
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_lane_id  = lane_id_q;
    assign o_overflow = overflow_q;

endmodule : block_collection_mux

// File: tb/tb_block_collection_mux.sv
// Self-checking bench for block_collection_mux: scoreboard on the output stream,
// a cycle table for stall/reject behaviour, and hand sequences for drain corner cases.
`timescale 1ns/1ps
module tb_block_collection_mux;

    localparam int LEN = 66;
    localparam int N   = 20;
    localparam int LW  = $clog2(N);

    typedef struct packed {
        logic [LEN-1:0] data;
        logic [LW-1:0]  lane;
    } sb_t;

    typedef struct {
        logic          load;
        logic          en;
        logic          exp_ready;
        logic          exp_valid;
        logic [LW-1:0] exp_lane;
        logic          exp_ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             i_reset;
    logic [N*LEN-1:0] i_lanes_data;
    logic             i_load;
    logic             i_enable;
    logic             o_ready;
    logic [LEN-1:0]   o_data;
    logic             o_valid;
    logic [LW-1:0]    o_lane_id;
    logic             o_overflow;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    block_collection_mux dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_lanes_data (i_lanes_data),
        .i_load       (i_load),
        .i_enable     (i_enable),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_lane_id    (o_lane_id),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every emitted block must be the next one the stimulus expected.
    always @(posedge clk) begin
        #1;
        if (o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 1, 0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_data", o_data, e.data);
                check("sb_lane", LEN'(o_lane_id), LEN'(e.lane));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [N*LEN-1:0] make_set(input logic [LEN-1:0] base);
        logic [N*LEN-1:0] s;
        for (int k = 0; k < N; k++) s[k*LEN +: LEN] = base + LEN'(k);
        return s;
    endfunction

    task automatic push_set(input logic [LEN-1:0] base);
        for (int k = 0; k < N; k++) sb_q.push_back('{data: base + LEN'(k), lane: LW'(k)});
    endtask

    task automatic load_set(input logic [LEN-1:0] base);
        i_lanes_data = make_set(base);
        i_load       = 1'b1;
        #1;
        check("load_ready", o_ready, 1);
        push_set(base);
        step();
        i_load = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_ready === 1'b1 && o_valid === 1'b0 && sb_q.size() == 0) begin
                ok = 1;
                break;
            end
            step();
        end
        check("wait_idle", ok, 1);
    endtask

    task automatic wait_lane(input int lane);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (o_valid === 1'b1 && o_lane_id == LW'(lane)) begin
                ok = 1;
                break;
            end
            step();
        end
        check("wait_lane", ok, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   run;
        bit   gap;
        bit   ovf_seen;
        int   nvalid;
        bit   late_valid;

        i_reset      = 1'b1;
        i_load       = 1'b0;
        i_enable     = 1'b1;
        i_lanes_data = '0;
        repeat (3) step();
        i_reset = 1'b0;
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_lane", LEN'(o_lane_id), 0);
        check("rst_ovf", o_overflow, 0);

        // Load with enable low, rejected loads, stall mid-drain.
        vecs = '{
            '{1'b1, 1'b0, 1'b1, 1'b0, LW'(0), 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, LW'(0), 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, LW'(0), 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, LW'(0), 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, LW'(0), 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, LW'(1), 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, LW'(2), 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, LW'(2), 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, LW'(3), 1'b0}
        };
        i_lanes_data = make_set(66'h0_5555_0000_0000_0000);
        for (int r = 0; r < 9; r++) begin
            i_load   = vecs[r].load;
            i_enable = vecs[r].en;
            #1;
            check($sformatf("tbl%0d_ready", r), o_ready, vecs[r].exp_ready);
            if (vecs[r].load && vecs[r].exp_ready) push_set(66'h0_5555_0000_0000_0000);
            step();
            check($sformatf("tbl%0d_valid", r), o_valid, vecs[r].exp_valid);
            check($sformatf("tbl%0d_lane", r), LEN'(o_lane_id), LEN'(vecs[r].exp_lane));
            check($sformatf("tbl%0d_ovf", r), o_overflow, vecs[r].exp_ovf);
        end
        i_load   = 1'b0;
        i_enable = 1'b1;
        wait_idle();

        // Single set, enable high: exactly N contiguous valid cycles.
        load_set(66'h1_0000_0000_0000_0000);
        check("t1_no_valid_on_accept", o_valid, 0);
        nvalid     = 0;
        late_valid = 0;
        for (int j = 0; j < N + 2; j++) begin
            step();
            if (j < N && o_valid === 1'b1) nvalid++;
            if (j >= N && o_valid !== 1'b0) late_valid = 1;
        end
        check("t1_valid_count", nvalid, N);
        check("t1_valid_after", late_valid, 0);
        check("t1_ready_after", o_ready, 1);

        // Back-to-back sets: second load on the cycle cnt==N-1.
        run      = 0;
        gap      = 0;
        ovf_seen = 0;
        load_set(66'h1_0000_0000_0000_0000);
        for (int j = 0; j < N - 1; j++) begin
            step();
            if (o_valid !== 1'b1) gap = 1; else if (!gap) run++;
            if (o_overflow !== 1'b0) ovf_seen = 1;
        end
        load_set(66'h3_0000_0000_0000_1000);
        if (o_valid !== 1'b1) gap = 1; else if (!gap) run++;
        if (o_overflow !== 1'b0) ovf_seen = 1;
        for (int j = 0; j < N + 2; j++) begin
            step();
            if (o_valid !== 1'b1) gap = 1; else if (!gap) run++;
            if (o_overflow !== 1'b0) ovf_seen = 1;
        end
        check("t2_contiguous", run, 2 * N);
        check("t2_gap_after", gap, 1);
        check("t2_no_overflow", ovf_seen, 0);
        wait_idle();

        // Load during cycle 5 of a drain is rejected and flagged once.
        load_set(66'h2_0000_0000_0000_0000);
        repeat (5) step();
        i_lanes_data = make_set(66'h3_FFFF_FFFF_0000_0000);
        i_load       = 1'b1;
        #1;
        check("t3_ready_busy", o_ready, 0);
        step();
        i_load = 1'b0;
        check("t3_ovf_pulse", o_overflow, 1);
        step();
        check("t3_ovf_clear", o_overflow, 0);
        wait_idle();

        // Enable low for 3 cycles after lane 7.
        load_set(66'h0_0000_0000_AAAA_0000);
        wait_lane(7);
        for (int j = 0; j < 3; j++) begin
            i_enable = 1'b0;
            #1;
            check("t4_ready_stall", o_ready, 0);
            step();
            check("t4_valid_stall", o_valid, 0);
        end
        i_enable = 1'b1;
        step();
        check("t4_resume_valid", o_valid, 1);
        check("t4_resume_lane", LEN'(o_lane_id), 8);
        wait_idle();

        // Reset mid-drain after lane 10; load in the reset cycle is ignored.
        load_set(66'h0_1234_5678_0000_0000);
        wait_lane(10);
        i_reset = 1'b1;
        i_load  = 1'b1;
        #1;
        check("t5_ready_in_reset", o_ready, 0);
        step();
        i_reset = 1'b0;
        i_load  = 1'b0;
        sb_q.delete();
        #1;
        check("t5_valid", o_valid, 0);
        check("t5_data", o_data, 0);
        check("t5_lane", LEN'(o_lane_id), 0);
        check("t5_ovf", o_overflow, 0);
        check("t5_ready", o_ready, 1);
        load_set(66'h0_0F0F_0000_0000_0000);
        step();
        check("t5_restart_lane0", LEN'(o_lane_id), 0);
        wait_idle();

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_block_collection_mux

// File: doc/block_collection_mux.md
# block_collection_mux

RX-side counterpart of the TX block distribution memory in the 100GbE PCS. It captures one 66-bit coded block from each of the N_LANES PCS lanes in a single load and serializes them back into one block stream in ascending lane order, 0 to N_LANES-1. It sits after lane deskew/reorder and feeds the descrambler/decoder. Back-to-back loads produce a gap-free output stream.

## Interface
- LEN_CODED_BLOCK, 66, coded block width (2-bit sync header + 64-bit payload)
- N_LANES, 20, number of PCS lanes; must be ≥2
- i_clock  in  1  single clock; all logic is rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_lanes_data  in  N_LANES*LEN_CODED_BLOCK  lane k block at bits [k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK]
- i_load  in  1  request to capture all lanes this cycle
- i_enable  in  1  output clock-enable; when low, emission stalls
- o_ready  out  1  combinational; a load is accepted this cycle
- o_data  out  LEN_CODED_BLOCK  serialized block, registered
- o_valid  out  1  o_data holds a new block this cycle, registered
- o_lane_id  out  $clog2(N_LANES)  lane index of o_data, registered
- o_overflow  out  1  one-cycle pulse: a load was rejected, registered

## Operation
- Lane bank: N_LANES x LEN_CODED_BLOCK registers. Next-index counter `cnt` is $clog2(N_LANES) bits wide. FSM has two states: IDLE and DRAIN.
- o_ready = (state==IDLE) | (state==DRAIN & cnt==N_LANES-1 & i_enable).
- Accepted load (i_load & o_ready):
  - bank <= i_lanes_data
  - cnt <= 0
  - state <= DRAIN
- DRAIN with i_enable=1, at each edge:
  - o_data <= bank[cnt], o_lane_id <= cnt, o_valid <= 1
  - If cnt==N_LANES-1 and no load: cnt <= 0, state <= IDLE. Otherwise cnt <= cnt+1.
  - When a load coincides with cnt==N_LANES-1, the last old block is emitted from the bank before it is overwritten. This is a same-edge read-before-write.
- DRAIN with i_enable=0: cnt, state and bank hold, o_data and o_lane_id hold, o_valid <= 0. A load cannot be accepted in this case, because o_ready is 0.
- IDLE: o_valid <= 0. o_data and o_lane_id hold. A load is accepted regardless of i_enable.
- Rejected load (i_load & ~o_ready): o_overflow <= 1 for one cycle. Bank, cnt and state are unaffected. Otherwise o_overflow <= 0.
- cnt never exceeds N_LANES-1. No wrap through unused codes when N_LANES is not a power of 2.

## Timing
- Reset values: state=IDLE, cnt=0, o_valid=0, o_data=0, o_lane_id=0, o_overflow=0. Bank contents are don't-care. o_ready=1 in the cycle after reset deasserts.
- Reset asserted mid-DRAIN: the next edge forces all reset values, and all remaining blocks are discarded. o_ready is 0 while i_reset=1, so a load in the reset cycle is neither accepted nor flagged.
- Latency: a load accepted at edge t gives lane 0 on o_data after edge t+1. With i_enable held high, lane k appears after edge t+1+k.
- Throughput: N_LANES blocks per N_LANES enabled cycles. A load on every N_LANES-th enabled cycle gives continuous o_valid.
- o_overflow rises one cycle after the rejected i_load.

## Structure
- LEN_CODED_BLOCK and N_LANES defaults go in the shared PCS package (pcs_pkg), alongside the TX distribution block. The lane index width is derived there as $clog2(N_LANES).
- FSM state encoding is local.
- No sub-module: bank, counter and FSM are flat in one module.

## Test plan
- Reset, then load lane k = 66'h1_0000_0000_0000_0000 + k, with i_enable=1 → lanes 0..19 appear in order on 20 consecutive cycles, o_lane_id 0..19, o_valid high for exactly 20 cycles, then o_ready=1.
- Two sets, second load pulsed on the cycle with cnt=19 → 40 contiguous o_valid cycles; lane 19 of set A is followed immediately by lane 0 of set B; o_overflow stays 0.
- Load at cycle 5 of a drain → o_overflow pulses once; output continues with the original set, data unchanged.
- i_enable low for 3 cycles after lane 7 → o_valid low for 3 cycles; lane 8 follows with no skip or repeat; o_ready stays 0.
- i_reset pulsed after lane 10 → the next cycle shows all outputs 0 and o_ready=1; a fresh load restarts at lane 0.
- Load in IDLE with i_enable=0, then raise i_enable after 4 cycles → lane 0 appears one cycle after i_enable rises.
